// File: rtl/rs_branch_queue.sv
// rs_branch_queue: collapsing-queue reservation station feeding the branch executor.
// Optional build macro RS_BRANCH_INORDER_EN restricts issue to the oldest entry only.
module rs_branch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NCDB  = 3,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned OP_W  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alloc_en,
  input  logic [XLEN-1:0]            alloc_pc,
  input  logic [OP_W-1:0]            alloc_op,
  input  logic [XLEN-1:0]            alloc_imm,
  input  logic [TAG_W-1:0]           alloc_tagx,
  input  logic [TAG_W-1:0]           alloc_tagy,
  input  logic [XLEN-1:0]            alloc_datax,
  input  logic [XLEN-1:0]            alloc_datay,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [NCDB-1:0]            cdb_valid,
  input  logic [NCDB*TAG_W-1:0]      cdb_tag,
  input  logic [NCDB*XLEN-1:0]       cdb_data,
  input  logic                       issue_ready,
  output logic                       issue_valid,
  output logic [XLEN-1:0]            issue_pc,
  output logic [XLEN-1:0]            issue_offset,
  output logic [XLEN-1:0]            issue_datax,
  output logic [XLEN-1:0]            issue_datay,
  output logic [OP_W-1:0]            issue_op
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tagx;
    logic [TAG_W-1:0] tagy;
    logic [XLEN-1:0]  datax;
    logic [XLEN-1:0]  datay;
  } entry_t;

  entry_t           r_q [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_full;

  entry_t           w_wk [DEPTH];
  entry_t           w_nq [DEPTH];
  entry_t           w_new;
  logic [DEPTH-1:0] w_ready;
  logic             w_any_ready;
  logic [IDX_W-1:0] w_sel;
  logic             w_fire;
  logic             w_alloc;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_n_count;
  logic [XLEN:0]    w_hx;
  logic [XLEN:0]    w_hy;
  logic [XLEN:0]    w_ax;
  logic [XLEN:0]    w_ay;

  // Returns {hit, data}; descending scan so the lowest matching channel wins.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [TAG_W-1:0]      tag,
    input logic [NCDB-1:0]       v,
    input logic [NCDB*TAG_W-1:0] t,
    input logic [NCDB*XLEN-1:0]  d
  );
    logic [XLEN:0] res;
    res = '0;
    for (int c = NCDB - 1; c >= 0; c--) begin
      if (tag != '0 && v[c] && t[c*TAG_W +: TAG_W] == tag) res = {1'b1, d[c*XLEN +: XLEN]};
    end
    return res;
  endfunction

  // Wakeup of stored entries plus the allocation bypass.
  always_comb begin
    w_hx = '0;
    w_hy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wk[i]    = r_q[i];
      w_ready[i] = r_q[i].valid && r_q[i].tagx == '0 && r_q[i].tagy == '0;
      w_hx = cdb_lookup(r_q[i].tagx, cdb_valid, cdb_tag, cdb_data);
      w_hy = cdb_lookup(r_q[i].tagy, cdb_valid, cdb_tag, cdb_data);
      if (w_hx[XLEN]) begin
        w_wk[i].tagx  = '0;
        w_wk[i].datax = w_hx[XLEN-1:0];
      end
      if (w_hy[XLEN]) begin
        w_wk[i].tagy  = '0;
        w_wk[i].datay = w_hy[XLEN-1:0];
      end
    end
    w_ax = cdb_lookup(alloc_tagx, cdb_valid, cdb_tag, cdb_data);
    w_ay = cdb_lookup(alloc_tagy, cdb_valid, cdb_tag, cdb_data);
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.pc    = alloc_pc;
    w_new.op    = alloc_op;
    w_new.imm   = alloc_imm;
    w_new.tagx  = w_ax[XLEN] ? '0 : alloc_tagx;
    w_new.datax = w_ax[XLEN] ? w_ax[XLEN-1:0] : alloc_datax;
    w_new.tagy  = w_ay[XLEN] ? '0 : alloc_tagy;
    w_new.datay = w_ay[XLEN] ? w_ay[XLEN-1:0] : alloc_datay;
  end

  // Issue select from stored state only.
  always_comb begin
    w_any_ready = 1'b0;
    w_sel       = '0;
`ifdef RS_BRANCH_INORDER_EN
    w_any_ready = w_ready[0];
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_any_ready = 1'b1;
        w_sel       = IDX_W'(i);
      end
    end
`endif
  end

  // Collapse past the fired entry, then append the allocation at the new tail.
  always_comb begin
    w_fire    = w_any_ready & issue_ready;
    w_alloc   = alloc_en & ~r_full;
    w_base    = r_count - CNT_W'(w_fire);
    w_n_count = w_base + CNT_W'(w_alloc);
    for (int j = 0; j < DEPTH - 1; j++) begin
      w_nq[j] = (w_fire && IDX_W'(j) >= w_sel) ? w_wk[j+1] : w_wk[j];
    end
    w_nq[DEPTH-1] = w_fire ? '0 : w_wk[DEPTH-1];
    if (w_alloc) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (CNT_W'(j) == w_base) w_nq[j] = w_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= w_nq[i];
      r_count <= w_n_count;
      r_full  <= (w_n_count == CNT_W'(DEPTH));
    end
  end

  assign full        = r_full;
  assign count       = r_count;
  assign issue_valid = w_any_ready;

  always_comb begin
    issue_pc     = '0;
    issue_offset = '0;
    issue_datax  = '0;
    issue_datay  = '0;
    issue_op     = '0;
    if (w_any_ready) begin
      issue_pc     = r_q[w_sel].pc;
      issue_offset = r_q[w_sel].imm;
      issue_datax  = r_q[w_sel].datax;
      issue_datay  = r_q[w_sel].datay;
      issue_op     = r_q[w_sel].op;
    end
  end

endmodule

// File: tb/tb_rs_branch_queue.sv
// tb_rs_branch_queue: directed and random stimulus against a queue-based reference model.
module tb_rs_branch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NCDB  = 3;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  alloc_en;
  logic [XLEN-1:0]       alloc_pc, alloc_imm, alloc_datax, alloc_datay;
  logic [OP_W-1:0]       alloc_op;
  logic [TAG_W-1:0]      alloc_tagx, alloc_tagy;
  logic                  full;
  logic [CNT_W-1:0]      count;
  logic [NCDB-1:0]       cdb_valid;
  logic [NCDB*TAG_W-1:0] cdb_tag;
  logic [NCDB*XLEN-1:0]  cdb_data;
  logic                  issue_ready;
  logic                  issue_valid;
  logic [XLEN-1:0]       issue_pc, issue_offset, issue_datax, issue_datay;
  logic [OP_W-1:0]       issue_op;

  rs_branch_queue #(.DEPTH(DEPTH), .NCDB(NCDB), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_en(alloc_en),
    .alloc_pc(alloc_pc), .alloc_op(alloc_op), .alloc_imm(alloc_imm),
    .alloc_tagx(alloc_tagx), .alloc_tagy(alloc_tagy),
    .alloc_datax(alloc_datax), .alloc_datay(alloc_datay),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_ready(issue_ready), .issue_valid(issue_valid),
    .issue_pc(issue_pc), .issue_offset(issue_offset),
    .issue_datax(issue_datax), .issue_datay(issue_datay), .issue_op(issue_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  pc, imm, dx, dy;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] tx, ty;
  } ent_t;

  ent_t q[$];
  int   exp_sel;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First (lowest-numbered) valid channel carrying a nonzero matching tag.
  function automatic logic lookup(input logic [TAG_W-1:0] t, output logic [XLEN-1:0] d);
    logic found;
    found = 1'b0;
    d = '0;
    for (int c = 0; c < NCDB; c++) begin
      if (!found && t != 0 && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) begin
        found = 1'b1;
        d = cdb_data[c*XLEN +: XLEN];
      end
    end
    return found;
  endfunction

  task automatic check_outputs();
    exp_sel = -1;
`ifdef RS_BRANCH_INORDER_EN
    if (q.size() > 0 && q[0].tx == 0 && q[0].ty == 0) exp_sel = 0;
`else
    for (int k = 0; k < q.size(); k++)
      if (exp_sel < 0 && q[k].tx == 0 && q[k].ty == 0) exp_sel = k;
`endif
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("issue_valid", 64'(issue_valid), 64'(exp_sel >= 0));
    if (exp_sel >= 0) begin
      chk("issue_pc", 64'(issue_pc), 64'(q[exp_sel].pc));
      chk("issue_offset", 64'(issue_offset), 64'(q[exp_sel].imm));
      chk("issue_op", 64'(issue_op), 64'(q[exp_sel].op));
      chk("issue_datax", 64'(issue_datax), 64'(q[exp_sel].dx));
      chk("issue_datay", 64'(issue_datay), 64'(q[exp_sel].dy));
    end else begin
      chk("issue_pc_idle", 64'(issue_pc), 64'(0));
      chk("issue_offset_idle", 64'(issue_offset), 64'(0));
      chk("issue_op_idle", 64'(issue_op), 64'(0));
      chk("issue_datax_idle", 64'(issue_datax), 64'(0));
      chk("issue_datay_idle", 64'(issue_datay), 64'(0));
    end
  endtask

  task automatic model_step();
    logic            full_b;
    logic [XLEN-1:0] d;
    ent_t            e;
    if (flush) begin
      q.delete();
    end else begin
      full_b = (q.size() == DEPTH);
      for (int k = 0; k < q.size(); k++) begin
        e = q[k];
        if (lookup(e.tx, d)) begin e.tx = 0; e.dx = d; end
        if (lookup(e.ty, d)) begin e.ty = 0; e.dy = d; end
        q[k] = e;
      end
      if (exp_sel >= 0 && issue_ready) q.delete(exp_sel);
      if (alloc_en && !full_b) begin
        e.pc = alloc_pc; e.imm = alloc_imm; e.op = alloc_op;
        e.tx = alloc_tagx; e.dx = alloc_datax;
        e.ty = alloc_tagy; e.dy = alloc_datay;
        if (lookup(alloc_tagx, d)) begin e.tx = 0; e.dx = d; end
        if (lookup(alloc_tagy, d)) begin e.ty = 0; e.dy = d; end
        q.push_back(e);
      end
    end
  endtask

  // Inputs are set at the falling edge before this is called.
  task automatic cycle();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    flush = 0; alloc_en = 0; alloc_pc = '0; alloc_imm = '0; alloc_op = '0;
    alloc_tagx = '0; alloc_tagy = '0; alloc_datax = '0; alloc_datay = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0; issue_ready = 0;
  endtask

  task automatic alloc(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                       input logic [TAG_W-1:0] tx, input logic [TAG_W-1:0] ty,
                       input logic [XLEN-1:0] dx, input logic [XLEN-1:0] dy);
    alloc_en = 1; alloc_pc = pc; alloc_imm = imm; alloc_op = OP_W'(pc[5:0]);
    alloc_tagx = tx; alloc_tagy = ty; alloc_datax = dx; alloc_datay = dy;
  endtask

  task automatic drain();
    set_idle();
    issue_ready = 1;
    repeat (DEPTH + 2) cycle();
  endtask

  task automatic rand_inputs();
    set_idle();
    alloc_en    = ($urandom_range(0, 9) < 6);
    alloc_pc    = $urandom;
    alloc_imm   = $urandom;
    alloc_op    = OP_W'($urandom);
    alloc_tagx  = ($urandom_range(0, 9) < 4) ? '0 : TAG_W'($urandom_range(1, 7));
    alloc_tagy  = ($urandom_range(0, 9) < 4) ? '0 : TAG_W'($urandom_range(1, 7));
    alloc_datax = $urandom;
    alloc_datay = $urandom;
    cdb_valid   = NCDB'($urandom);
    for (int c = 0; c < NCDB; c++) begin
      cdb_tag[c*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
      cdb_data[c*XLEN +: XLEN]  = $urandom;
    end
    issue_ready = 1'($urandom_range(0, 1));
    flush       = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    set_idle();
    rst = 0;
    exp_sel = -1;
    repeat (2) @(negedge clk);
    #1;
    check_outputs();
    rst = 1;
    @(negedge clk);

    // Single resolved branch: one-cycle latency, then drains.
    alloc(32'h100, 32'd8, 0, 0, 32'd5, 32'd5);
    issue_ready = 1;
    cycle();
    chk("t1_valid", 64'(issue_valid), 64'(1));
    chk("t1_pc", 64'(issue_pc), 64'h100);
    chk("t1_off", 64'(issue_offset), 64'd8);
    set_idle(); issue_ready = 1;
    cycle();
    chk("t1_count", 64'(count), 64'(0));

    // Older pending entry A, younger ready entry B, later wakeup of A.
    set_idle(); alloc(32'h200, 32'd4, 4'd3, 0, 32'd0, 32'd9);
    cycle();
    set_idle(); alloc(32'h300, 32'd4, 0, 0, 32'd1, 32'd2);
    cycle();
    set_idle(); issue_ready = 1;
`ifdef RS_BRANCH_INORDER_EN
    chk("t2_first_valid", 64'(issue_valid), 64'(0));
`else
    chk("t2_first_pc", 64'(issue_pc), 64'h300);
`endif
    cycle();
    set_idle(); issue_ready = 1;
    cdb_valid = 3'b010; cdb_tag[1*TAG_W +: TAG_W] = 4'd3; cdb_data[1*XLEN +: XLEN] = 32'h2A;
    cycle();
    chk("t2_a_pc", 64'(issue_pc), 64'h200);
    chk("t2_a_datax", 64'(issue_datax), 64'h2A);
    drain();

    // Fill to full, reject alloc while full, even when firing that cycle.
    set_idle();
    for (int k = 0; k < DEPTH; k++) begin
      alloc(32'h400 + 32'(k), 32'(k), 0, 0, 32'(k), 32'(k));
      cycle();
    end
    chk("t3_full", 64'(full), 64'(1));
    alloc(32'h4FF, 0, 0, 0, 0, 0);
    cycle();
    chk("t3_cnt_hold", 64'(count), 64'(DEPTH));
    alloc(32'h4FE, 0, 0, 0, 0, 0); issue_ready = 1;
    cycle();
    chk("t3_cnt_fire", 64'(count), 64'(DEPTH - 1));
    drain();

    // Same-cycle allocation bypass.
    set_idle(); alloc(32'h500, 32'd0, 0, 4'd5, 32'd1, 32'd0);
    cdb_valid = 3'b001; cdb_tag[0 +: TAG_W] = 4'd5; cdb_data[0 +: XLEN] = 32'h77;
    cycle();
    chk("t4_valid", 64'(issue_valid), 64'(1));
    chk("t4_datay", 64'(issue_datay), 64'h77);
    drain();

    // Two channels match: lowest channel wins.
    set_idle(); alloc(32'h600, 32'd0, 4'd6, 0, 32'd0, 32'd3);
    cycle();
    set_idle();
    cdb_valid = 3'b101;
    cdb_tag[0 +: TAG_W] = 4'd6; cdb_data[0 +: XLEN] = 32'h11;
    cdb_tag[2*TAG_W +: TAG_W] = 4'd6; cdb_data[2*XLEN +: XLEN] = 32'h22;
    cycle();
    chk("t5_datax", 64'(issue_datax), 64'h11);
    drain();

    // Flush beats alloc and fire.
    set_idle();
    for (int k = 0; k < 3; k++) begin
      alloc(32'h700 + 32'(k), 0, 0, 0, 0, 0);
      cycle();
    end
    alloc(32'h7FF, 0, 0, 0, 0, 0); issue_ready = 1; flush = 1;
    cycle();
    chk("t6_count", 64'(count), 64'(0));
    chk("t6_valid", 64'(issue_valid), 64'(0));

    // Random traffic with an asynchronous reset in the middle.
    for (int n = 0; n < 800; n++) begin
      rand_inputs();
      if (n == 400) begin
        #2 rst = 0;
        #1 q.delete();
        check_outputs();
        chk("async_count", 64'(count), 64'(0));
        @(negedge clk);
        rst = 1;
      end else begin
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rs_branch_queue.md
Name: rs_branch_queue

Overview:
Multi-entry reservation station for the branch unit.
- Buffers up to DEPTH branch instructions from the allocator.
- Snoops NCDB result-broadcast channels to wake up pending operands.
- Issues the oldest entry whose operands are both ready to the branch executor using a valid/ready handshake.
- Replaces the single-slot branch station. Adds depth, a parametrised broadcast channel count, full back-pressure, same-cycle wakeup bypass and flush.

Parameters:
DEPTH, 4, number of entries (2..16)
NCDB, 3, number of result-broadcast channels (alu0, alu1, ls by default)
XLEN, 32, data/pc/immediate width
TAG_W, 4, register-tag width; tag value 0 = UNLOCKED (operand data valid)
OP_W, 6, branch sub-opcode width

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  asynchronous active-low reset (0 = reset asserted)
flush  in  1  synchronous kill of all entries (mispredict)
alloc_en  in  1  allocate request, honoured only when full=0
alloc_pc  in  XLEN  pc of branch
alloc_op  in  OP_W  branch op
alloc_imm  in  XLEN  branch offset
alloc_tagx / alloc_tagy  in  TAG_W  source tags
alloc_datax / alloc_datay  in  XLEN  source data (valid when tag=0)
full  out  1  count==DEPTH
count  out  $clog2(DEPTH+1)  occupied entries
cdb_valid  in  NCDB  per-channel broadcast valid
cdb_tag  in  NCDB*TAG_W  packed tags, channel i at [i*TAG_W +: TAG_W]
cdb_data  in  NCDB*XLEN  packed data, same packing
issue_ready  in  1  branch executor can accept
issue_valid  out  1  a ready entry is presented
issue_pc / issue_offset / issue_datax / issue_datay  out  XLEN  selected entry fields
issue_op  out  OP_W  selected entry op

Behaviour:
- Reset (rst=0, async): all entries invalid, tags 0, data/pc/op 0; count=0, full=0, issue_valid=0, all issue_* fields 0.
- Storage is a collapsing queue. Index 0 is the oldest entry. Valid entries occupy indices 0..count-1.
- Wakeup, every posedge: for each valid entry and each operand with tag!=0, if any channel i has cdb_valid[i]=1 and cdb_tag[i]==tag, the entry loads cdb_data[i] and sets its tag to 0.
  - If several channels match, the lowest channel index wins.
  - cdb_valid with cdb_tag=0 is ignored.
- Allocation bypass: an incoming operand whose alloc_tag matches a same-cycle valid broadcast is written already resolved (tag 0, broadcast data).
- Ready rule: entry ready = valid and tagx==0 and tagy==0, using stored state only. Wakeup in cycle N makes the entry issuable in cycle N+1.
- Issue:
  - Combinational select of the lowest-index ready entry; issue_* are driven from that entry.
  - issue_valid=1 iff any entry is ready; issue_* are 0 when issue_valid=0.
  - fire = issue_valid & issue_ready. On fire, the selected entry is removed at posedge and younger entries shift down one index.
  - Branch latency: alloc at edge N with resolved operands gives issue_valid=1 during cycle N+1.
- Allocation: if alloc_en=1 and full=0, the new entry is written at index (count - fire) after the shift. If full=1, alloc_en is ignored, with no error signal.
- Count update: alloc and fire in the same cycle keeps count unchanged. full is registered state only, so a full queue rejects alloc even when firing that cycle.
- Flush: flush=1 at posedge invalidates all entries and sets count to 0. Flush overrides alloc and fire; a same-cycle fire is not consumed.
- Shift carries wakeup: an entry both shifting and being woken in one cycle lands at its new index with the updated tag/data.

Optional Feature:
RS_BRANCH_INORDER_EN
- Defined: only index 0 may issue. issue_valid = entry0 valid and ready. Younger ready entries wait, giving strict program-order branch resolution.
- Undefined: oldest-ready selection as described above.

Test Plan:
- Reset then alloc pc=0x100, imm=8, tags 0/0, data 5/5, issue_ready=1 -> issue_valid=1 next cycle with issue_pc=0x100, issue_offset=8; count returns to 0 after fire.
- Alloc A (tagx=3) then B (ready) -> B issues first; broadcast ch1 tag 3 data 0x2A -> A issues next cycle with issue_datax=0x2A. With RS_BRANCH_INORDER_EN: B waits until A issues.
- Fill DEPTH=4 with issue_ready=0 -> full=1; fifth alloc ignored (count stays 4); one fire plus alloc in the same cycle -> alloc rejected, count=3.
- Alloc tagy=5 while ch0 broadcasts tag 5 data 0x77 same cycle -> entry issues next cycle with datay=0x77.
- Channels 0 and 2 both broadcast tag 6 (data 0x11, 0x22) -> pending operand gets 0x11.
- 3 entries valid, flush=1 with alloc_en=1 and a fire -> count=0, issue_valid=0; async rst=0 mid-operation -> all outputs 0 immediately, before the next edge.
